// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM states, CSR addresses
// and CSR reset/command values.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4
    } trap_state_e;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_MIPD   = 12'h100;

    localparam int unsigned TVEC_BASE_DFLT = 32'h0000_F000;
    // Value software writes to mipd to leave the handler.
    localparam int unsigned MIPD_DONE      = 1;

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-first priority encoder: request vector -> {valid, winning index}.
module trap_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan high to low so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/exception controller: arbitrates sources, captures machine CSRs and sequences
// stall/flush/redirect into and out of the handler. `TRAP_VECTORED_EN selects vectored targets.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               NUM_SRC     = 4,
    parameter logic [XLEN-1:0]  TVEC_BASE   = XLEN'(TVEC_BASE_DFLT),
    parameter int               TVEC_STRIDE = 4,
    parameter int               CAUSE_BASE  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      exc_req,
    input  logic [XLEN-1:0]         exc_pc,
    input  logic [NUM_SRC*XLEN-1:0] exc_tval,
    input  logic [11:0]             csr_radd,
    output logic [XLEN-1:0]         csr_rdata,
    input  logic [11:0]             csr_wadd,
    input  logic [XLEN-1:0]         csr_wdata,
    input  logic                    csr_wen,
    output logic                    stall,
    output logic                    flush,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    in_trap,
    output logic                    double_fault
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif
    localparam logic [XLEN-1:0] STRIDE_EFF = VEC_EN ? XLEN'(TVEC_STRIDE) : '0;

    trap_state_e      state_q, state_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [XLEN-1:0]  cap_pc_q, cap_pc_d;
    logic [XLEN-1:0]  cap_tval_q, cap_tval_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d;
    logic [XLEN-1:0]  mepc_q, mepc_d;
    logic [XLEN-1:0]  mcause_q, mcause_d;
    logic [XLEN-1:0]  mtval_q, mtval_d;
    logic [XLEN-1:0]  mipd_q, mipd_d;
    logic             double_fault_q, double_fault_d;

    logic             req_vld;
    logic [IDX_W-1:0] req_idx;
    logic [XLEN-1:0]  tval_arr [NUM_SRC];
    logic             ret_req;

    trap_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_prio (
        .req   (exc_req),
        .valid (req_vld),
        .idx   (req_idx)
    );

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_tval
        assign tval_arr[g] = exc_tval[g*XLEN +: XLEN];
    end

    assign ret_req = csr_wen && (csr_wadd == CSR_MIPD) && (csr_wdata == XLEN'(MIPD_DONE));

    always_comb begin
        state_d        = state_q;
        cap_idx_d      = cap_idx_q;
        cap_pc_d       = cap_pc_q;
        cap_tval_d     = cap_tval_q;
        double_fault_d = double_fault_q;
        stall          = double_fault_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        in_trap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d    = CAPTURE;
                    cap_idx_d  = req_idx;
                    cap_pc_d   = exc_pc;
                    cap_tval_d = tval_arr[req_idx];
                end
            end
            CAPTURE: begin
                stall   = 1'b1;
                flush   = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_q + STRIDE_EFF * XLEN'(cap_idx_q);
                flush          = 1'b1;
                state_d        = HANDLER;
            end
            HANDLER: begin
                in_trap = 1'b1;
                if (|exc_req) double_fault_d = 1'b1;
                if (ret_req) state_d = RETURN;
            end
            RETURN: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_q;
                flush          = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Software writes first; the hardware capture/return updates override them.
    always_comb begin
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mipd_d   = mipd_q;
        if (csr_wen) begin
            case (csr_wadd)
                CSR_MTVEC:  mtvec_d  = csr_wdata;
                CSR_MEPC:   mepc_d   = csr_wdata;
                CSR_MCAUSE: mcause_d = csr_wdata;
                CSR_MTVAL:  mtval_d  = csr_wdata;
                CSR_MIPD:   mipd_d   = csr_wdata;
                default: ;
            endcase
        end
        if (state_q == CAPTURE) begin
            mepc_d   = cap_pc_q;
            mcause_d = XLEN'(CAUSE_BASE) + XLEN'(cap_idx_q);
            mtval_d  = cap_tval_q;
            mipd_d   = '0;
        end
        if (state_q == RETURN) mipd_d = '0;
    end

    always_comb begin
        case (csr_radd)
            CSR_MTVEC:  csr_rdata = mtvec_q;
            CSR_MEPC:   csr_rdata = mepc_q;
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MTVAL:  csr_rdata = mtval_q;
            CSR_MIPD:   csr_rdata = mipd_q;
            default:    csr_rdata = '0;
        endcase
    end

    assign double_fault = double_fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cap_idx_q      <= '0;
            cap_pc_q       <= '0;
            cap_tval_q     <= '0;
            mtvec_q        <= TVEC_BASE;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mipd_q         <= '0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cap_idx_q      <= cap_idx_d;
            cap_pc_q       <= cap_pc_d;
            cap_tval_q     <= cap_tval_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mipd_q         <= mipd_d;
            double_fault_q <= double_fault_d;
        end
    end

endmodule
